// File: rtl/gyro_lane_serdes.sv
// Multi-lane word serializer/deserializer sharing one divided bit clock and frame counter,
// with AXI-stream word ports on the transmit and receive sides.
module gyro_lane_serdes #(
   parameter int WIDTH = 48,
   parameter int LANES = 1,
   parameter int PKT_W = 13
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [7:0]               clk_div,
   input  logic [1:0]               mode,
   input  logic                     tx_start_stop,
   input  logic                     rx_start_stop,
   input  logic [PKT_W-1:0]         pkt_len,
   input  logic                     status_clear,
   input  logic [WIDTH*LANES-1:0]   tx_tdata,
   input  logic                     tx_tvalid,
   output logic                     tx_tready,
   input  logic                     tx_tlast,
   output logic [WIDTH*LANES-1:0]   rx_tdata,
   output logic                     rx_tvalid,
   input  logic                     rx_tready,
   output logic                     rx_tlast,
   output logic [LANES-1:0]         dtx,
   input  logic [LANES-1:0]         drx,
   output logic                     dsync,
   output logic                     mck,
   output logic                     tx_underrun,
   output logic                     rx_overflow
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} tx_state_t;

   logic [7:0]             div_cnt;
   logic                   mck_i;
   logic [BW-1:0]          bit_cnt;
   tx_state_t              state;
   logic                   last_tlast;
   logic [WIDTH-1:0]       tx_sh [LANES];
   logic [WIDTH-1:0]       rx_sh [LANES];
   logic [LANES-1:0]       sample;
   logic [WIDTH*LANES-1:0] word;
   logic [PKT_W-1:0]       pkt_cnt;

   logic half_tick, rise, fall, bit_last, boundary;
   logic tx_hs, underrun_set, rx_done, rx_accept, hit_last;

   assign half_tick = enable && (div_cnt >= clk_div);
   assign rise      = half_tick && !mck_i;
   assign fall      = half_tick && mck_i;
   assign bit_last  = (bit_cnt == BIT_LAST);
   assign boundary  = rise && bit_last;

   assign tx_tready    = boundary && tx_start_stop && enable && (state == IDLE || bit_last);
   assign tx_hs        = tx_tready && tx_tvalid;
   assign underrun_set = boundary && (state == SHIFT) && tx_start_stop && !tx_tvalid && !last_tlast;

   assign dsync = enable && bit_last;
   // The bit clock is suppressed between words only while a transmit run is requested.
   assign mck   = (enable && tx_start_stop) ? (mck_i && state == SHIFT) : mck_i;

   assign rx_done   = fall && bit_last && rx_start_stop && enable;
   assign rx_accept = rx_done && (!rx_tvalid || rx_tready);
   assign hit_last  = (pkt_len != '0) && (pkt_cnt == pkt_len - PKT_W'(1));

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      dtx    = '0;
      sample = '0;
      word   = '0;
      for (int n = 0; n < LANES; n++) begin
         dtx[n]    = (state == SHIFT) && tx_sh[n][WIDTH-1];
         sample[n] = (mode == 2'b01) ? dtx[n] : drx[n];
         word[n*WIDTH +: WIDTH] = {rx_sh[n][WIDTH-2:0], sample[n]};
      end
   end

   // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         mck_i   <= 1'b0;
         bit_cnt <= '0;
      end else if (!enable) begin
         div_cnt <= '0;
         mck_i   <= 1'b0;
         bit_cnt <= '0;
      end else if (half_tick) begin
         div_cnt <= '0;
         mck_i   <= !mck_i;
         if (rise) bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   // NOTE: the per-lane shift registers are ordinary flops, so they are reset with everything else.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         last_tlast  <= 1'b0;
         tx_underrun <= 1'b0;
         for (int n = 0; n < LANES; n++) tx_sh[n] <= '0;
      end else begin
         if (!enable) begin
            state <= IDLE;
            for (int n = 0; n < LANES; n++) tx_sh[n] <= '0;
         end else if (boundary) begin
            if (tx_hs) begin
               state      <= SHIFT;
               last_tlast <= tx_tlast;
               for (int n = 0; n < LANES; n++) tx_sh[n] <= tx_tdata[n*WIDTH +: WIDTH];
            end else begin
               state <= IDLE;
               for (int n = 0; n < LANES; n++) tx_sh[n] <= '0;
            end
         end else if (rise && state == SHIFT) begin
            for (int n = 0; n < LANES; n++) tx_sh[n] <= {tx_sh[n][WIDTH-2:0], 1'b0};
         end

         if (underrun_set)      tx_underrun <= 1'b1;
         else if (status_clear) tx_underrun <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_tdata    <= '0;
         rx_tvalid   <= 1'b0;
         rx_tlast    <= 1'b0;
         pkt_cnt     <= '0;
         rx_overflow <= 1'b0;
         for (int n = 0; n < LANES; n++) rx_sh[n] <= '0;
      end else begin
         if (!enable) begin
            for (int n = 0; n < LANES; n++) rx_sh[n] <= '0;
         end else if (fall) begin
            for (int n = 0; n < LANES; n++) rx_sh[n] <= word[n*WIDTH +: WIDTH];
         end

         if (rx_accept) begin
            rx_tdata  <= word;
            rx_tvalid <= 1'b1;
            rx_tlast  <= hit_last;
         end else if (rx_tvalid && rx_tready) begin
            rx_tvalid <= 1'b0;
            rx_tlast  <= 1'b0;
         end

         // Dropped words never advance the packet position.
         if (!rx_start_stop || pkt_len == '0) pkt_cnt <= '0;
         else if (rx_accept)                  pkt_cnt <= hit_last ? '0 : pkt_cnt + PKT_W'(1);

         if (rx_done && !rx_accept) rx_overflow <= 1'b1;
         else if (status_clear)     rx_overflow <= 1'b0;
      end
   end

endmodule
